// File: rtl/dram_writer_audio.sv
// Packs 16-bit PCM samples into 128-bit chunks and issues {addr, data} write commands.
// Optional feature: define DRAM_WRITER_CHECKSUM_EN to add a running 16-bit sample checksum output.
module dram_writer_audio (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [23:0]  base_addr,
   input  logic         sample_axis_tvalid,
   output logic         sample_axis_tready,
   input  logic [15:0]  sample_axis_tdata,
   input  logic         sample_axis_tlast,
   output logic         chunk_axis_tvalid,
   input  logic         chunk_axis_tready,
   output logic [151:0] chunk_axis_tdata,
   output logic         busy,
   output logic         done,
`ifdef DRAM_WRITER_CHECKSUM_EN
   output logic [15:0]  checksum,
`endif
   output logic [23:0]  end_addr
);

   localparam int unsigned SAMPLE_W = 16;
   localparam int unsigned DATA_W   = 128;
   localparam int unsigned ADDR_W   = 24;
   localparam int unsigned LANES    = DATA_W / SAMPLE_W;
   localparam int unsigned LANE_W   = $clog2(LANES);

   typedef enum logic [1:0] {IDLE, FILL, SEND, DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   end_addr_q, end_addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic                last_q, last_d;
   logic                tready_q, tready_d;
   logic                tvalid_q, tvalid_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
`ifdef DRAM_WRITER_CHECKSUM_EN
   logic [SAMPLE_W-1:0] csum_q, csum_d;
`endif

   // Next-state and datapath; handshake outputs are registered from the next state.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      end_addr_d = end_addr_q;
      data_d     = data_q;
      lane_d     = lane_q;
      last_d     = last_q;
`ifdef DRAM_WRITER_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FILL;
               addr_d  = base_addr;
               lane_d  = '0;
               data_d  = '0;
               last_d  = 1'b0;
`ifdef DRAM_WRITER_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         FILL: begin
            if (sample_axis_tvalid && tready_q) begin
               data_d[{lane_q, 4'b0000} +: SAMPLE_W] = sample_axis_tdata;
               lane_d = lane_q + LANE_W'(1);
`ifdef DRAM_WRITER_CHECKSUM_EN
               csum_d = csum_q + sample_axis_tdata;
`endif
               if (sample_axis_tlast || (lane_q == LANE_W'(LANES - 1))) begin
                  state_d = SEND;
                  last_d  = sample_axis_tlast;
               end
            end
         end
         SEND: begin
            if (chunk_axis_tready) begin
               addr_d  = addr_q + ADDR_W'(1);
               lane_d  = '0;
               data_d  = '0;
               state_d = last_q ? DONE : FILL;
               // Capture the final address here so end_addr is already valid when done pulses.
               if (last_q) begin
                  end_addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      tready_d = (state_d == FILL);
      tvalid_d = (state_d == SEND);
      busy_d   = (state_d != IDLE);
      done_d   = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         end_addr_q <= '0;
         data_q     <= '0;
         lane_q     <= '0;
         last_q     <= 1'b0;
         tready_q   <= 1'b0;
         tvalid_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef DRAM_WRITER_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         end_addr_q <= end_addr_d;
         data_q     <= data_d;
         lane_q     <= lane_d;
         last_q     <= last_d;
         tready_q   <= tready_d;
         tvalid_q   <= tvalid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef DRAM_WRITER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   assign sample_axis_tready = tready_q;
   assign chunk_axis_tvalid  = tvalid_q;
   assign chunk_axis_tdata   = {addr_q, data_q};
   assign busy               = busy_q;
   assign done               = done_q;
   assign end_addr           = end_addr_q;
`ifdef DRAM_WRITER_CHECKSUM_EN
   assign checksum           = csum_q;
`endif

endmodule

// File: tb/tb_dram_writer_audio.sv
// Self-checking bench for dram_writer_audio: vector table, hand sequences and random loads vs a chunk model.
module tb_dram_writer_audio;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [23:0]  base_addr;
   logic         sample_axis_tvalid;
   logic         sample_axis_tready;
   logic [15:0]  sample_axis_tdata;
   logic         sample_axis_tlast;
   logic         chunk_axis_tvalid;
   logic         chunk_axis_tready;
   logic [151:0] chunk_axis_tdata;
   logic         busy;
   logic         done;
   logic [23:0]  end_addr;
`ifdef DRAM_WRITER_CHECKSUM_EN
   logic [15:0]  checksum;
`endif

   dram_writer_audio dut (
      .clk                (clk),
      .rst                (rst),
      .start              (start),
      .base_addr          (base_addr),
      .sample_axis_tvalid (sample_axis_tvalid),
      .sample_axis_tready (sample_axis_tready),
      .sample_axis_tdata  (sample_axis_tdata),
      .sample_axis_tlast  (sample_axis_tlast),
      .chunk_axis_tvalid  (chunk_axis_tvalid),
      .chunk_axis_tready  (chunk_axis_tready),
      .chunk_axis_tdata   (chunk_axis_tdata),
      .busy               (busy),
      .done               (done),
`ifdef DRAM_WRITER_CHECKSUM_EN
      .checksum           (checksum),
`endif
      .end_addr           (end_addr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [15:0]  smp_q[$];
   logic [151:0] exp_q[$];
   logic [151:0] got_q[$];

   bit           rdy_rand  = 1'b0;
   bit           rdy_fixed = 1'b1;
   bit           hold_v    = 1'b0;
   logic [151:0] hold_d;

   typedef struct {
      logic [23:0] base;
      int          n;
      logic [15:0] first;
      bit          ms;
      int          exp_chunks;
      logic [23:0] exp_end;
   } vec_t;

   vec_t vt[7];

   task automatic check(input string name, input logic [151:0] act, input logic [151:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: split the sample list into groups of eight, zero-fill the tail, addresses count up mod 2^24.
   task automatic build_expected(input logic [23:0] base);
      int          nch;
      logic [127:0] d;
      exp_q.delete();
      nch = (smp_q.size() + 7) / 8;
      for (int k = 0; k < nch; k++) begin
         d = '0;
         for (int j = 0; j < 8; j++)
            if (k * 8 + j < smp_q.size()) d[16*j +: 16] = smp_q[k*8 + j];
         exp_q.push_back({24'(base + 24'(k)), d});
      end
   endtask

   // Chunk ready source: random or fixed level, changed only at falling edges.
   always begin
      @(negedge clk);
      chunk_axis_tready = rdy_rand ? ($urandom_range(0, 2) != 0) : rdy_fixed;
   end

   // Chunk monitor plus hold-stability check while the controller back-pressures.
   always begin
      @(negedge clk);
      #3;
      if (hold_v) begin
         check("hold_tvalid", 152'(chunk_axis_tvalid), 152'(1'b1));
         check("hold_tdata", chunk_axis_tdata, hold_d);
      end
      if (rst && chunk_axis_tvalid && chunk_axis_tready) got_q.push_back(chunk_axis_tdata);
      hold_v = rst && chunk_axis_tvalid && !chunk_axis_tready;
      hold_d = chunk_axis_tdata;
   end

   task automatic feed(input logic [23:0] base, input bit stall, input bit ms, input bit with_last);
      int idx = 0;
      int guard = 0;
      int n = smp_q.size();
      build_expected(base);
      got_q.delete();
      @(negedge clk);
      start = 1'b1;
      base_addr = base;
      while (idx < n && guard < 5000) begin
         @(negedge clk);
         start = ms && (idx == 3);
         base_addr = start ? 24'h999999 : 24'($urandom);
         if (!stall || $urandom_range(0, 3) != 0) begin
            sample_axis_tvalid = 1'b1;
            sample_axis_tdata  = smp_q[idx];
            sample_axis_tlast  = with_last && (idx == n - 1);
         end else begin
            sample_axis_tvalid = 1'b0;
            sample_axis_tdata  = 16'($urandom);
            sample_axis_tlast  = 1'($urandom_range(0, 1));
         end
         #3;
         if (sample_axis_tvalid && sample_axis_tready) idx++;
         guard++;
      end
      if (idx < n) check("sample_timeout", 152'(idx), 152'(n));
      @(negedge clk);
      sample_axis_tvalid = 1'b0;
      sample_axis_tlast  = 1'b0;
      start = 1'b0;
   endtask

   task automatic wait_check(input logic [23:0] exp_end);
      int guard = 0;
      logic [15:0] cs = '0;
      while (!done && guard < 500) begin
         @(negedge clk);
         #3;
         guard++;
      end
      check("done_seen", 152'(done), 152'(1'b1));
      check("end_addr", 152'(end_addr), 152'(exp_end));
`ifdef DRAM_WRITER_CHECKSUM_EN
      foreach (smp_q[i]) cs = 16'(cs + smp_q[i]);
      check("checksum", 152'(checksum), 152'(cs));
`else
      cs = '0;
`endif
      @(negedge clk);
      #3;
      check("done_busy_after", 152'({done, busy}), 152'(2'b00));
      check("chunk_count", 152'(got_q.size()), 152'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check("chunk", got_q[i], exp_q[i]);
   endtask

   initial begin
      vt[0] = '{24'h000100, 8,  16'h0001, 1'b0, 1, 24'h000101};
      vt[1] = '{24'h000010, 11, 16'h1000, 1'b0, 2, 24'h000012};
      vt[2] = '{24'hFFFFFF, 16, 16'h2000, 1'b0, 2, 24'h000001};
      vt[3] = '{24'h000050, 1,  16'h7FFF, 1'b0, 1, 24'h000051};
      vt[4] = '{24'hABCDE0, 7,  16'h8000, 1'b1, 1, 24'hABCDE1};
      vt[5] = '{24'h123456, 9,  16'hFFF0, 1'b1, 2, 24'h123458};
      vt[6] = '{24'hFFFFFE, 24, 16'h0100, 1'b0, 3, 24'h000001};

      rst = 1'b0;
      start = 1'b0;
      base_addr = '0;
      sample_axis_tvalid = 1'b0;
      sample_axis_tdata = '0;
      sample_axis_tlast = 1'b0;
      chunk_axis_tready = 1'b1;
      repeat (3) @(negedge clk);
      #3;
      check("reset_outputs", 152'({busy, done, chunk_axis_tvalid, sample_axis_tready}), 152'(4'b0000));
      check("reset_end_addr", 152'(end_addr), 152'(24'h0));
      @(negedge clk);
      rst = 1'b1;

      // Single full chunk, no stalls, against a fixed literal.
      smp_q.delete();
      for (int i = 1; i <= 8; i++) smp_q.push_back(16'(i));
      feed(24'h000100, 1'b0, 1'b0, 1'b1);
      wait_check(24'h000101);
      if (got_q.size() > 0)
         check("literal_chunk", got_q[0], {24'h000100, 128'h0008_0007_0006_0005_0004_0003_0002_0001});

      // Long back-pressure: chunk must be held, sample side closed.
      rdy_rand = 1'b0;
      rdy_fixed = 1'b0;
      smp_q.delete();
      for (int i = 0; i < 8; i++) smp_q.push_back(16'(16'hA000 + i));
      feed(24'h000200, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         sample_axis_tvalid = 1'b1;
         sample_axis_tdata  = 16'hDEAD;
         #3;
         check("bp_tvalid", 152'(chunk_axis_tvalid), 152'(1'b1));
         check("bp_tdata", chunk_axis_tdata, exp_q[0]);
         check("bp_sample_tready", 152'(sample_axis_tready), 152'(1'b0));
      end
      @(negedge clk);
      sample_axis_tvalid = 1'b0;
      rdy_fixed = 1'b1;
      wait_check(24'h000201);

      // Reset mid-load abandons the partial chunk.
      smp_q.delete();
      for (int i = 0; i < 5; i++) smp_q.push_back(16'(16'h5000 + i));
      feed(24'h000300, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #3;
      check("rst_mid_tvalid", 152'(chunk_axis_tvalid), 152'(1'b0));
      check("rst_mid_busy", 152'(busy), 152'(1'b0));
      repeat (10) @(negedge clk);
      check("rst_no_chunk", 152'(got_q.size()), 152'(0));
      smp_q.delete();
      for (int i = 0; i < 8; i++) smp_q.push_back(16'(16'h6000 + i));
      feed(24'h000400, 1'b0, 1'b0, 1'b1);
      wait_check(24'h000401);

`ifdef DRAM_WRITER_CHECKSUM_EN
      smp_q.delete();
      smp_q.push_back(16'hFFFF);
      smp_q.push_back(16'h0002);
      feed(24'h000500, 1'b0, 1'b0, 1'b1);
      wait_check(24'h000501);
      check("checksum_literal", 152'(checksum), 152'(16'h0001));
`endif

      // Vector table under random stalls on both sides.
      rdy_rand = 1'b1;
      for (int v = 0; v < 7; v++) begin
         smp_q.delete();
         for (int i = 0; i < vt[v].n; i++) smp_q.push_back(16'(vt[v].first + 16'(i)));
         feed(vt[v].base, 1'b1, vt[v].ms, 1'b1);
         wait_check(vt[v].exp_end);
         check("table_chunks", 152'(got_q.size()), 152'(vt[v].exp_chunks));
      end

      // Random loads against the model.
      for (int r = 0; r < 25; r++) begin
         logic [23:0] b;
         int n;
         b = 24'($urandom);
         if (r % 5 == 0) b = 24'hFFFFFF - 24'($urandom_range(0, 2));
         n = $urandom_range(1, 20);
         smp_q.delete();
         for (int i = 0; i < n; i++) smp_q.push_back(16'($urandom));
         feed(b, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
         wait_check(24'(b + 24'(exp_q.size())));
      end

      rdy_rand = 1'b0;
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
